// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - FSM encodings shared by the SRAM arbiter and its bench
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_RD   = 2'd1,
        ARB_WR   = 2'd2,
        ARB_TURN = 2'd3
    } arb_state_e;

    // Steady state reached after accepting an op of the given direction
    function automatic arb_state_e dir_state(input logic we);
        return we ? ARB_WR : ARB_RD;
    endfunction

endpackage

// File: rtl/sram_arb_tag_pipe.sv
// rtl/sram_arb_tag_pipe.sv - read tag delay line tracking which port owns each read
module sram_arb_tag_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  logic push_port,
    output logic empty,
    output logic out_valid,
    output logic out_port
);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] port_q, port_d;

    // Advance every tag one stage per cycle; new read tags enter stage 0
    always_comb begin
        vld_d     = vld_q;
        port_d    = port_q;
        vld_d[0]  = push;
        port_d[0] = push_port;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i]  = vld_q[i-1];
            port_d[i] = port_q[i-1];
        end
    end

    // Tag registers; reset drops every in-flight read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q  <= '0;
            port_q <= '0;
        end else begin
            vld_q  <= vld_d;
            port_q <= port_d;
        end
    end

    assign empty     = ~|vld_q;
    assign out_valid = vld_q[DEPTH-1];
    assign out_port  = port_q[DEPTH-1];

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port round-robin arbiter with bus turnaround in front of the SRAM controller
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_BITS    = 20,
    parameter int DATA_BITS    = 16,
    parameter int READ_LATENCY = 2,
    parameter int TURN_CYCLES  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 p0_req_valid,
    output logic                 p0_req_ready,
    input  logic                 p0_req_we,
    input  logic [ADDR_BITS-1:0] p0_req_addr,
    input  logic [DATA_BITS-1:0] p0_req_wdata,
    output logic                 p0_resp_valid,
    output logic [DATA_BITS-1:0] p0_resp_rdata,
    input  logic                 p1_req_valid,
    output logic                 p1_req_ready,
    input  logic                 p1_req_we,
    input  logic [ADDR_BITS-1:0] p1_req_addr,
    input  logic [DATA_BITS-1:0] p1_req_wdata,
    output logic                 p1_resp_valid,
    output logic [DATA_BITS-1:0] p1_resp_rdata,
    output logic                 mem_valid,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic [DATA_BITS-1:0] mem_rdata,
    output logic [1:0]           arb_state
);

    localparam int CW = $clog2(TURN_CYCLES + 2);

    arb_state_e           state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 turn_port_q, turn_port_d;
    logic                 turn_we_q, turn_we_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 mem_valid_q, mem_valid_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_BITS-1:0] mem_wdata_q, mem_wdata_d;
    logic                 mem_port_q, mem_port_d;
    logic                 p0_resp_valid_q, p0_resp_valid_d;
    logic                 p1_resp_valid_q, p1_resp_valid_d;
    logic [DATA_BITS-1:0] p0_resp_rdata_q, p0_resp_rdata_d;
    logic [DATA_BITS-1:0] p1_resp_rdata_q, p1_resp_rdata_d;

    logic any_valid, win_port, win_we;
    logic accept, acc_port, acc_we;
    logic tag_empty, tag_out_valid, tag_out_port;

    assign any_valid = p0_req_valid | p1_req_valid;
    assign win_port  = (p0_req_valid & p1_req_valid) ? ~last_grant_q : p1_req_valid;
    assign win_we    = win_port ? p1_req_we : p0_req_we;

    // Arbitration and direction FSM: accept same-direction winners, park opposite ones in TURN
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        turn_port_d  = turn_port_q;
        turn_we_d    = turn_we_q;
        cnt_d        = cnt_q;
        accept       = 1'b0;
        acc_port     = win_port;
        case (state_q)
            ARB_IDLE: accept = any_valid;
            ARB_RD, ARB_WR: begin
                if (any_valid) begin
                    if (win_we == (state_q == ARB_WR)) begin
                        accept = 1'b1;
                    end else begin
                        turn_port_d = win_port;
                        turn_we_d   = win_we;
                        cnt_d       = '0;
                        state_d     = ARB_TURN;
                    end
                end
            end
            ARB_TURN: begin
                // Locked to the parked port so the other side cannot ping-pong it out
                acc_port = turn_port_q;
                if (!tag_empty) begin
                    cnt_d = '0;
                end else if (cnt_q != CW'(TURN_CYCLES)) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    accept = turn_port_q ? p1_req_valid : p0_req_valid;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        acc_we = acc_port ? p1_req_we : p0_req_we;
        if (accept) begin
            state_d      = dir_state((state_q == ARB_TURN) ? turn_we_q : acc_we);
            last_grant_d = acc_port;
            cnt_d        = '0;
        end
    end

    // Command register and read-return steering
    always_comb begin
        mem_valid_d     = accept;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        mem_port_d      = mem_port_q;
        if (accept) begin
            mem_we_d    = acc_we;
            mem_addr_d  = acc_port ? p1_req_addr : p0_req_addr;
            mem_wdata_d = acc_port ? p1_req_wdata : p0_req_wdata;
            mem_port_d  = acc_port;
        end
        p0_resp_valid_d = tag_out_valid & ~tag_out_port;
        p1_resp_valid_d = tag_out_valid & tag_out_port;
        p0_resp_rdata_d = p0_resp_valid_d ? mem_rdata : p0_resp_rdata_q;
        p1_resp_rdata_d = p1_resp_valid_d ? mem_rdata : p1_resp_rdata_q;
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ARB_IDLE;
            last_grant_q    <= 1'b1;
            turn_port_q     <= 1'b0;
            turn_we_q       <= 1'b0;
            cnt_q           <= '0;
            mem_valid_q     <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_port_q      <= 1'b0;
            p0_resp_valid_q <= 1'b0;
            p1_resp_valid_q <= 1'b0;
            p0_resp_rdata_q <= '0;
            p1_resp_rdata_q <= '0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            turn_port_q     <= turn_port_d;
            turn_we_q       <= turn_we_d;
            cnt_q           <= cnt_d;
            mem_valid_q     <= mem_valid_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_port_q      <= mem_port_d;
            p0_resp_valid_q <= p0_resp_valid_d;
            p1_resp_valid_q <= p1_resp_valid_d;
            p0_resp_rdata_q <= p0_resp_rdata_d;
            p1_resp_rdata_q <= p1_resp_rdata_d;
        end
    end

    // A read enters the tag pipe on the same cycle its command is on the bus
    sram_arb_tag_pipe #(
        .DEPTH(READ_LATENCY)
    ) u_tag_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (mem_valid_q & ~mem_we_q),
        .push_port (mem_port_q),
        .empty     (tag_empty),
        .out_valid (tag_out_valid),
        .out_port  (tag_out_port)
    );

    // Ready is held low while reset is asserted so no request is taken during it
    assign p0_req_ready  = reset_n & accept & ~acc_port;
    assign p1_req_ready  = reset_n & accept & acc_port;
    assign mem_valid     = mem_valid_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign p0_resp_valid = p0_resp_valid_q;
    assign p1_resp_valid = p1_resp_valid_q;
    assign p0_resp_rdata = p0_resp_rdata_q;
    assign p1_resp_rdata = p1_resp_rdata_q;
    assign arb_state     = state_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        p0_req_valid, p0_req_we, p1_req_valid, p1_req_we;
    logic [19:0] p0_req_addr, p1_req_addr;
    logic [15:0] p0_req_wdata, p1_req_wdata;

    logic        p0_req_ready, p1_req_ready, p0_resp_valid, p1_resp_valid;
    logic [15:0] p0_resp_rdata, p1_resp_rdata;
    logic        mem_valid, mem_we;
    logic [19:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic [1:0]  arb_state;

    logic        p0_req_ready_b, p1_req_ready_b, p0_resp_valid_b, p1_resp_valid_b;
    logic [15:0] p0_resp_rdata_b, p1_resp_rdata_b;
    logic        mem_valid_b, mem_we_b;
    logic [19:0] mem_addr_b;
    logic [15:0] mem_wdata_b;
    logic [15:0] mem_rdata_b = 16'hBEEF;
    logic [1:0]  arb_state_b;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc_n   = 0;
    logic        mon_en  = 1'b0;
    logic        exp_v0 [0:2047];
    logic        exp_v1 [0:2047];
    logic [15:0] exp_d0 [0:2047];
    logic [15:0] exp_d1 [0:2047];
    logic [15:0] rd_pipe0 = '0;
    logic [15:0] rd_pipe1 = '0;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_BITS(20), .DATA_BITS(16), .READ_LATENCY(2), .TURN_CYCLES(1)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
        .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
        .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
        .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
        .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .arb_state(arb_state)
    );

    sram_arbiter #(.ADDR_BITS(20), .DATA_BITS(16), .READ_LATENCY(2), .TURN_CYCLES(0)) u_dut_b (
        .clk(clk), .reset_n(reset_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready_b), .p0_req_we(p0_req_we),
        .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
        .p0_resp_valid(p0_resp_valid_b), .p0_resp_rdata(p0_resp_rdata_b),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready_b), .p1_req_we(p1_req_we),
        .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
        .p1_resp_valid(p1_resp_valid_b), .p1_resp_rdata(p1_resp_rdata_b),
        .mem_valid(mem_valid_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata_b), .arb_state(arb_state_b)
    );

    // SRAM model: read data appears two cycles after the command, derived from the address
    always @(posedge clk) begin
        rd_pipe0 <= (mem_valid && !mem_we) ? mem_addr[15:0] : 16'h0000;
        rd_pipe1 <= rd_pipe0;
        cyc_n    <= cyc_n + 1;
    end
    assign mem_rdata = rd_pipe1 ^ 16'h5A5A;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Response strobes every cycle against the expectation table
    always begin
        @(negedge clk);
        #2;
        if (mon_en) begin
            check_eq("p0_resp_valid", 32'(p0_resp_valid), 32'(exp_v0[cyc_n]));
            check_eq("p1_resp_valid", 32'(p1_resp_valid), 32'(exp_v1[cyc_n]));
            if (exp_v0[cyc_n]) check_eq("p0_resp_rdata", 32'(p0_resp_rdata), 32'(exp_d0[cyc_n]));
            if (exp_v1[cyc_n]) check_eq("p1_resp_rdata", 32'(p1_resp_rdata), 32'(exp_d1[cyc_n]));
        end
    end

    task automatic set_p0(input logic v, input logic we, input logic [19:0] a, input logic [15:0] d);
        p0_req_valid = v; p0_req_we = we; p0_req_addr = a; p0_req_wdata = d;
    endtask

    task automatic set_p1(input logic v, input logic we, input logic [19:0] a, input logic [15:0] d);
        p1_req_valid = v; p1_req_we = we; p1_req_addr = a; p1_req_wdata = d;
    endtask

    // Check readies; an expected read acceptance schedules its response 4 cycles later
    task automatic step(input string tag, input logic e0, input logic e1);
        #1;
        check_eq({tag, " p0_ready"}, 32'(p0_req_ready), 32'(e0));
        check_eq({tag, " p1_ready"}, 32'(p1_req_ready), 32'(e1));
        if (e0 && p0_req_valid && !p0_req_we) begin
            exp_v0[cyc_n+4] = 1'b1;
            exp_d0[cyc_n+4] = p0_req_addr[15:0] ^ 16'h5A5A;
        end
        if (e1 && p1_req_valid && !p1_req_we) begin
            exp_v1[cyc_n+4] = 1'b1;
            exp_d1[cyc_n+4] = p1_req_addr[15:0] ^ 16'h5A5A;
        end
    endtask

    task automatic step_b(input string tag, input logic e0, input logic e1);
        #1;
        check_eq({tag, " b p0_ready"}, 32'(p0_req_ready_b), 32'(e0));
        check_eq({tag, " b p1_ready"}, 32'(p1_req_ready_b), 32'(e1));
    endtask

    task automatic mem_chk(input string tag, input logic [19:0] a, input logic we, input logic [15:0] d);
        check_eq({tag, " mem_valid"}, 32'(mem_valid), 32'd1);
        check_eq({tag, " mem_we"},    32'(mem_we),    32'(we));
        check_eq({tag, " mem_addr"},  32'(mem_addr),  32'(a));
        check_eq({tag, " mem_wdata"}, 32'(mem_wdata), 32'(d));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            set_p0(1'b0, 1'b0, 20'h0, 16'h0);
            set_p1(1'b0, 1'b0, 20'h0, 16'h0);
            step("idle", 1'b0, 1'b0);
        end
    endtask

    logic [19:0] a0, a1, last_a;

    initial begin
        for (int i = 0; i < 2048; i++) begin
            exp_v0[i] = 1'b0; exp_v1[i] = 1'b0; exp_d0[i] = '0; exp_d1[i] = '0;
        end
        reset_n = 1'b0;
        set_p0(1'b1, 1'b0, 20'h0, 16'h0);
        set_p1(1'b0, 1'b0, 20'h0, 16'h0);

        // Reset state: everything zero even with a request present
        @(negedge clk); #1;
        check_eq("rst p0_ready",  32'(p0_req_ready), 32'd0);
        check_eq("rst mem_valid", 32'(mem_valid),    32'd0);
        check_eq("rst arb_state", 32'(arb_state),    32'(ARB_IDLE));
        check_eq("rst resp",      32'(p0_resp_valid | p1_resp_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        set_p0(1'b0, 1'b0, 20'h0, 16'h0);
        mon_en = 1'b1;

        // 1: single write
        @(negedge clk);
        set_p0(1'b1, 1'b1, 20'h00010, 16'hA5A5);
        step("t1", 1'b1, 1'b0);
        @(negedge clk);
        set_p0(1'b0, 1'b0, 20'h0, 16'h0);
        step("t1 idle", 1'b0, 1'b0);
        mem_chk("t1", 20'h00010, 1'b1, 16'hA5A5);
        check_eq("t1 state", 32'(arb_state), 32'(ARB_WR));

        // 3: write then read from the other port -> turnaround
        @(negedge clk);
        set_p1(1'b1, 1'b0, 20'h00020, 16'h0);
        step("t3 conflict", 1'b0, 1'b0);
        check_eq("t3 mem_valid drop", 32'(mem_valid), 32'd0);
        @(negedge clk);
        step("t3 turn", 1'b0, 1'b0);
        check_eq("t3 state turn", 32'(arb_state), 32'(ARB_TURN));
        @(negedge clk);
        step("t3 accept", 1'b0, 1'b1);
        @(negedge clk);
        set_p1(1'b0, 1'b0, 20'h0, 16'h0);
        step("t3 idle", 1'b0, 1'b0);
        mem_chk("t3", 20'h00020, 1'b0, 16'h0);
        check_eq("t3 state rd", 32'(arb_state), 32'(ARB_RD));
        idle(5);

        // 2: both ports reading continuously alternate, p0 first
        a0 = 20'h00100; a1 = 20'h00200; last_a = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_p0(1'b1, 1'b0, a0, 16'h0);
            set_p1(1'b1, 1'b0, a1, 16'h0);
            step("t2", (i % 2) == 0, (i % 2) == 1);
            if (i > 0) mem_chk("t2", last_a, 1'b0, 16'h0);
            if ((i % 2) == 0) begin last_a = a0; a0 = a0 + 20'd1; end
            else begin last_a = a1; a1 = a1 + 20'd1; end
        end
        idle(1);
        mem_chk("t2 last", last_a, 1'b0, 16'h0);
        idle(5);

        // 4: three p1 reads then a p0 write waits for the tag pipe, and keeps its lock
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_p1(1'b1, 1'b0, a1, 16'h0);
            step("t4 rd", 1'b0, 1'b1);
            a1 = a1 + 20'd1;
        end
        for (int k = 3; k <= 10; k++) begin
            @(negedge clk);
            if (k == 3) begin
                set_p0(1'b1, 1'b1, 20'h00300, 16'h1234);
                set_p1(1'b1, 1'b0, 20'h002F0, 16'h0);
            end
            if (k == 8) set_p0(1'b0, 1'b0, 20'h0, 16'h0);
            step("t4", k == 7, k == 10);
            if (k == 5) check_eq("t4 state turn", 32'(arb_state), 32'(ARB_TURN));
            if (k == 8) mem_chk("t4 wr", 20'h00300, 1'b1, 16'h1234);
        end
        idle(1);
        mem_chk("t4 rd", 20'h002F0, 1'b0, 16'h0);
        idle(6);

        // 5: reset with two reads in flight
        @(negedge clk);
        set_p0(1'b1, 1'b0, 20'h00400, 16'h0);
        step("t5 rd0", 1'b1, 1'b0);
        @(negedge clk);
        set_p0(1'b0, 1'b0, 20'h0, 16'h0);
        set_p1(1'b1, 1'b0, 20'h00500, 16'h0);
        step("t5 rd1", 1'b0, 1'b1);
        @(negedge clk);
        reset_n = 1'b0;
        for (int i = 0; i < 16; i++) begin exp_v0[cyc_n+i] = 1'b0; exp_v1[cyc_n+i] = 1'b0; end
        set_p1(1'b0, 1'b0, 20'h0, 16'h0);
        set_p0(1'b1, 1'b1, 20'h00040, 16'h1111);
        #1;
        check_eq("t5 rst mem_valid", 32'(mem_valid),    32'd0);
        check_eq("t5 rst arb_state", 32'(arb_state),    32'(ARB_IDLE));
        check_eq("t5 rst p0_ready",  32'(p0_req_ready), 32'd0);
        check_eq("t5 rst mem_addr",  32'(mem_addr),     32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        set_p0(1'b1, 1'b1, 20'h00600, 16'h6666);
        set_p1(1'b1, 1'b1, 20'h00700, 16'h7777);
        step("t5 tie", 1'b1, 1'b0);
        @(negedge clk);
        set_p0(1'b0, 1'b0, 20'h0, 16'h0);
        step("t5 p1", 1'b0, 1'b1);
        mem_chk("t5 p0w", 20'h00600, 1'b1, 16'h6666);
        @(negedge clk);
        set_p1(1'b0, 1'b0, 20'h0, 16'h0);
        step("t5 end", 1'b0, 1'b0);
        mem_chk("t5 p1w", 20'h00700, 1'b1, 16'h7777);
        idle(6);

        // 6: TURN_CYCLES=0 instance, alternating p0 write / p1 read
        mon_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        set_p0(1'b1, 1'b1, 20'h00800, 16'h0808);
        step_b("t6 w0", 1'b1, 1'b0);
        @(negedge clk);
        set_p0(1'b0, 1'b0, 20'h0, 16'h0);
        set_p1(1'b1, 1'b0, 20'h00900, 16'h0);
        step_b("t6 conflict", 1'b0, 1'b0);
        @(negedge clk);
        step_b("t6 rd", 1'b0, 1'b1);
        check_eq("t6 state turn", 32'(arb_state_b), 32'(ARB_TURN));
        @(negedge clk);
        set_p1(1'b0, 1'b0, 20'h0, 16'h0);
        set_p0(1'b1, 1'b1, 20'h00801, 16'h0809);
        step_b("t6 conflict2", 1'b0, 1'b0);
        check_eq("t6 mem_valid", 32'(mem_valid_b), 32'd1);
        check_eq("t6 mem_we",    32'(mem_we_b),    32'd0);
        check_eq("t6 mem_addr",  32'(mem_addr_b),  32'h00900);
        @(negedge clk);
        step_b("t6 drain1", 1'b0, 1'b0);
        @(negedge clk);
        step_b("t6 drain2", 1'b0, 1'b0);
        @(negedge clk);
        step_b("t6 w1", 1'b1, 1'b0);
        check_eq("t6 resp valid", 32'(p1_resp_valid_b), 32'd1);
        check_eq("t6 resp data",  32'(p1_resp_rdata_b), 32'hBEEF);
        check_eq("t6 p0 resp",    32'(p0_resp_valid_b), 32'd0);
        @(negedge clk);
        set_p0(1'b0, 1'b0, 20'h0, 16'h0);
        step_b("t6 end", 1'b0, 1'b0);
        check_eq("t6 wdata",      32'(mem_wdata_b),     32'h0809);
        check_eq("t6 p0 rdata",   32'(p0_resp_rdata_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
